// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG encoder output path: packer FSM states,
// JPEG marker/stuffing constants and the lane-count to byte-strobe helper.
package jpeg_enc_pkg;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_PAD   = 3'd1,
    S_MARK0 = 3'd2,
    S_MARK1 = 3'd3,
    S_LAST  = 3'd4
  } state_e;

  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI_CODE      = 8'hD9;

  localparam int MAX_CODE_W = 16;

  // Byte lanes are always filled contiguously from lane 0.
  function automatic logic [3:0] lanes_to_strb(input logic [2:0] n);
    logic [3:0] strb;
    case (n)
      3'd0:    strb = 4'b0000;
      3'd1:    strb = 4'b0001;
      3'd2:    strb = 4'b0011;
      3'd3:    strb = 4'b0111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/jpeg_bitpack_word.sv
// Byte-to-32-bit beat assembler. Collects bytes into lanes 0..3 and holds a
// full word back until either another byte is waiting (so the word is known
// not to be last) or the segment end is signalled. Outputs are driven
// straight from registers, so they stay put while valid && !accept.
module jpeg_bitpack_word
  import jpeg_enc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        end_i,
  output logic        done_o,
  output logic        empty_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic [3:0]  outport_strb_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i
);

  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        fire;

  // Lane fill, hold-back of full words and end-of-segment presentation.
  always_comb begin
    // NOTE: every _d signal gets its default first so no latch is inferred.
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    fire    = valid_q && outport_accept_i;
    // A full non-last word frees up in its accept cycle: the waiting byte
    // goes straight into lane 0 of the next word.
    byte_ready_o = (!valid_q && (cnt_q != 3'd4)) || (fire && !last_q);

    if (fire) begin
      data_d  = 32'h0;
      cnt_d   = 3'd0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (byte_valid_i && !last_q) begin
        data_d[7:0] = byte_data_i;
        cnt_d       = 3'd1;
      end
    end else if (!valid_q) begin
      if (byte_valid_i) begin
        if (cnt_q == 3'd4) begin
          valid_d = 1'b1;
        end else begin
          case (cnt_q[1:0])
            2'd0:    data_d[7:0]   = byte_data_i;
            2'd1:    data_d[15:8]  = byte_data_i;
            2'd2:    data_d[23:16] = byte_data_i;
            default: data_d[31:24] = byte_data_i;
          endcase
          cnt_d = cnt_q + 3'd1;
        end
      end else if (end_i) begin
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
    end
  end

  // Word register state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses <= only; the word register is reset
    // because it drives the stream outputs directly.
    if (!rst_i) begin
      data_q  <= 32'h0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign done_o          = fire && last_q;
  assign empty_o         = (cnt_q == 3'd0) && !valid_q;
  assign outport_valid_o = valid_q;
  assign outport_last_o  = last_q;
  assign outport_strb_o  = valid_q ? lanes_to_strb(cnt_q) : 4'b0000;
  assign outport_data_o  = valid_q ? data_q : 32'h0;

endmodule

// File: rtl/jpeg_bitpacker.sv
// JPEG entropy-coded-segment bit packer. Packs MSB-first Huffman codes into
// bytes with 0xFF/0x00 stuffing, pads the final byte with PAD_BIT on flush
// and hands bytes to jpeg_bitpack_word for 32-bit beat output.
// Build option: define JPEG_BITPACK_EOI_EN to append the EOI marker
// (0xFF,0xD9) after the pad byte of every flushed segment.
module jpeg_bitpacker
  import jpeg_enc_pkg::*;
#(
  parameter bit PAD_BIT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_data_i,
  input  logic [4:0]  inport_width_i,
  input  logic        inport_flush_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic [3:0]  outport_strb_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i,
  output logic        idle_o
);

  // Bits 22..15 form the next byte out of the accumulator.
  localparam logic [22:0] TOP_BYTE_MASK = 23'h7F8000;

  state_e      state_q, state_d;
  logic [22:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        stuff_q, stuff_d;
  logic        en_q, en_d;

  logic [4:0]  code_w;
  logic [15:0] code_mask;
  logic [15:0] code_bits;
  logic [4:0]  ins_shift;
  logic        take;
  logic        byte_vld;
  logic [7:0]  byte_val;
  logic        byte_rdy;
  logic        byte_wr;
  logic        word_done;
  logic        word_empty;

  // Code insertion, byte extraction with stuffing, padding and marker FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stuff_d = stuff_q;
    en_d    = 1'b1;

    code_w    = (inport_width_i > 5'(MAX_CODE_W)) ? 5'(MAX_CODE_W) : inport_width_i;
    code_mask = 16'((17'd1 << code_w) - 17'd1);
    code_bits = inport_data_i & code_mask;
    ins_shift = 5'd23 - cnt_q - code_w;

    // en_q keeps the input closed while reset is asserted and for the
    // first cycle after it.
    inport_accept_o = en_q && (state_q == S_RUN) && (cnt_q < 5'd8) && !stuff_q;
    take            = inport_valid_i && inport_accept_o;

    byte_vld = 1'b0;
    byte_val = 8'h00;
    if (stuff_q) begin
      byte_vld = 1'b1;
      byte_val = JPEG_STUFF_BYTE;
    end else if (cnt_q >= 5'd8) begin
      byte_vld = 1'b1;
      byte_val = acc_q[22:15];
`ifdef JPEG_BITPACK_EOI_EN
    end else if (state_q == S_MARK0) begin
      byte_vld = 1'b1;
      byte_val = JPEG_MARKER_PREFIX;
    end else if (state_q == S_MARK1) begin
      byte_vld = 1'b1;
      byte_val = JPEG_EOI_CODE;
`endif
    end
    byte_wr = byte_vld && byte_rdy;

    // Insertion needs cnt<8 and no stuff pending, extraction needs one of
    // them, so the two never coincide.
    if (byte_wr) begin
      if (stuff_q) begin
        stuff_d = 1'b0;
      end else if (cnt_q >= 5'd8) begin
        acc_d   = acc_q << 8;
        cnt_d   = cnt_q - 5'd8;
        stuff_d = (acc_q[22:15] == JPEG_MARKER_PREFIX);
      end
    end

    if (take) begin
      acc_d = acc_q | ({7'b0, code_bits} << ins_shift);
      cnt_d = cnt_q + code_w;
      if (inport_flush_i) state_d = S_PAD;
    end

    case (state_q)
      S_PAD: begin
        if (!stuff_q && (cnt_q == 5'd0)) begin
`ifdef JPEG_BITPACK_EOI_EN
          state_d = S_MARK0;
`else
          state_d = S_LAST;
`endif
        end else if (!stuff_q && (cnt_q < 5'd8)) begin
          // Bits below the valid ones are already zero, so only a 1 pad
          // needs an explicit fill.
          if (PAD_BIT) acc_d = acc_q | ((TOP_BYTE_MASK >> cnt_q) & TOP_BYTE_MASK);
          cnt_d = 5'd8;
        end
      end
`ifdef JPEG_BITPACK_EOI_EN
      S_MARK0: if (byte_wr) state_d = S_MARK1;
      S_MARK1: if (byte_wr) state_d = S_LAST;
`endif
      S_LAST:  if (word_done) state_d = S_RUN;
      default: ;
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RUN;
      acc_q   <= 23'h0;
      cnt_q   <= 5'd0;
      stuff_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stuff_q <= stuff_d;
      en_q    <= en_d;
    end
  end

  jpeg_bitpack_word u_word (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .byte_valid_i     (byte_vld),
    .byte_data_i      (byte_val),
    .byte_ready_o     (byte_rdy),
    .end_i            (state_q == S_LAST),
    .done_o           (word_done),
    .empty_o          (word_empty),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_strb_o   (outport_strb_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i)
  );

  assign idle_o = (state_q == S_RUN) && (cnt_q == 5'd0) && !stuff_q && word_empty;

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Self-checking bench for jpeg_bitpacker: directed segment table, random
// codes against a bit-queue reference packer under output backpressure,
// and a mid-segment reset. Expectations follow JPEG_BITPACK_EOI_EN.
module tb_jpeg_bitpacker;

  logic        clk_i;
  logic        rst_i;
  logic        inport_valid_i;
  logic [15:0] inport_data_i;
  logic [4:0]  inport_width_i;
  logic        inport_flush_i;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic [3:0]  outport_strb_o;
  logic        outport_last_o;
  logic        outport_accept_i;
  logic        idle_o;

  jpeg_bitpacker #(.PAD_BIT(1'b1)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_width_i   (inport_width_i),
    .inport_flush_i   (inport_flush_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_strb_o   (outport_strb_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i),
    .idle_o           (idle_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  typedef struct {
    int               n_codes;
    logic [9:0][15:0] d;
    logic [9:0][4:0]  w;
    int               n_beats;
    logic [1:0][31:0] bd;
    logic [1:0][3:0]  bs;
  } vec_t;

  int      n_checks = 0;
  int      n_errors = 0;
  beat_t   beat_q[$];
  bit      stall_en = 0;
  bit      saw_drop = 0;
  int      cyc = 0;
  bit      prev_stall = 0;
  beat_t   prev_beat;
  vec_t    vecs[9];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output ready: always high, or alternating 10-cycle low/high windows.
  initial begin
    outport_accept_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      outport_accept_i = stall_en ? (((cyc / 10) % 2) == 0) : 1'b1;
    end
  end

  // Beat capture, hold-stability check and input-backpressure observation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable",
              {outport_valid_o, outport_data_o, outport_strb_o, outport_last_o},
              {1'b1, prev_beat.data, prev_beat.strb, prev_beat.last});
      if (outport_valid_o && outport_accept_i)
        beat_q.push_back('{outport_data_o, outport_strb_o, outport_last_o});
      if (stall_en && inport_valid_i && !inport_accept_o) saw_drop = 1'b1;
      prev_stall     = outport_valid_o && !outport_accept_i;
      prev_beat.data = outport_data_o;
      prev_beat.strb = outport_strb_o;
      prev_beat.last = outport_last_o;
    end
  end

  task automatic send_code(input logic [15:0] d, input logic [4:0] w, input logic f);
    bit done = 0;
    int budget = 2000;
    inport_valid_i = 1'b1;
    inport_data_i  = d;
    inport_width_i = w;
    inport_flush_i = f;
    while (!done && budget > 0) begin
      @(negedge clk_i);
      if (inport_accept_o) done = 1;
      @(posedge clk_i);
      #1;
      budget--;
    end
    inport_valid_i = 1'b0;
    inport_flush_i = 1'b0;
    if (!done) check("send_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_last(output bit ok);
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(posedge clk_i);
      #2;
      foreach (beat_q[i]) if (beat_q[i].last) ok = 1;
    end
    check("last_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    for (int i = 0; i < v.n_codes; i++)
      send_code(v.d[i], v.w[i], (i == v.n_codes - 1));
    wait_last(ok);
    check({tag, "_beats"}, 64'(beat_q.size()), 64'(v.n_beats));
    for (int b = 0; b < v.n_beats && b < beat_q.size(); b++) begin
      check($sformatf("%s_b%0d_data", tag, b), 64'(beat_q[b].data), 64'(v.bd[b]));
      check($sformatf("%s_b%0d_strb", tag, b), 64'(beat_q[b].strb), 64'(v.bs[b]));
      check($sformatf("%s_b%0d_last", tag, b), 64'(beat_q[b].last), 64'(b == v.n_beats - 1));
    end
    check({tag, "_idle"}, 64'(idle_o), 64'd1);
    beat_q.delete();
  endtask

  task automatic set_code(input int v, input int i, input logic [15:0] d, input logic [4:0] w);
    vecs[v].d[i] = d;
    vecs[v].w[i] = w;
  endtask

  task automatic set_beats(input int v, input int n, input logic [31:0] d0, input logic [3:0] s0,
                           input logic [31:0] d1, input logic [3:0] s1);
    vecs[v].n_beats = n;
    vecs[v].bd[0] = d0; vecs[v].bs[0] = s0;
    vecs[v].bd[1] = d1; vecs[v].bs[1] = s1;
  endtask

  initial begin
    bit ok;
    bit          mq[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  got_b[$];
    logic [7:0]  by;
    logic [15:0] rd;
    logic [4:0]  rw;
    int          ew;
    int          bad_strb;

    // Directed segments; flush rides on the final code of each.
    vecs[0].n_codes = 9;
    for (int i = 0; i < 8; i++) set_code(0, i, 16'h0001, 5'd1);
    set_code(0, 8, 16'h0000, 5'd0);
    vecs[1].n_codes = 3;
    set_code(1, 0, 16'hABCD, 5'd16); set_code(1, 1, 16'h1234, 5'd16); set_code(1, 2, 16'h0, 5'd0);
    vecs[2].n_codes = 1;
    set_code(2, 0, 16'h0005, 5'd3);
    vecs[3].n_codes = 1;
    set_code(3, 0, 16'h0000, 5'd0);
    vecs[4].n_codes = 3;
    set_code(4, 0, 16'hFFF5, 5'd4); set_code(4, 1, 16'h0003, 5'd20); set_code(4, 2, 16'h0, 5'd0);
    vecs[5].n_codes = 3;
    set_code(5, 0, 16'h00FF, 5'd8); set_code(5, 1, 16'h0012, 5'd8); set_code(5, 2, 16'h0, 5'd0);
    vecs[6].n_codes = 1;
    set_code(6, 0, 16'h007F, 5'd7);
    vecs[7].n_codes = 3;
    set_code(7, 0, 16'h00AA, 5'd8); set_code(7, 1, 16'h1234, 5'd0); set_code(7, 2, 16'h0055, 5'd8);
    vecs[8].n_codes = 3;
    set_code(8, 0, 16'h0102, 5'd16); set_code(8, 1, 16'h0304, 5'd16); set_code(8, 2, 16'h0005, 5'd8);
`ifdef JPEG_BITPACK_EOI_EN
    set_beats(0, 1, 32'hD9FF00FF, 4'b1111, 32'h0, 4'b0);
    set_beats(1, 2, 32'h3412CDAB, 4'b1111, 32'h000000D9 << 0 | 32'h0000D900 >> 8 | 32'h0000D9FF, 4'b0011);
    set_beats(2, 1, 32'h00D9FFBF, 4'b0111, 32'h0, 4'b0);
    set_beats(3, 1, 32'h0000D9FF, 4'b0011, 32'h0, 4'b0);
    set_beats(4, 2, 32'hFF3F0050, 4'b1111, 32'h000000D9, 4'b0001);
    set_beats(5, 2, 32'hFF1200FF, 4'b1111, 32'h000000D9, 4'b0001);
    set_beats(6, 1, 32'hD9FF00FF, 4'b1111, 32'h0, 4'b0);
    set_beats(7, 1, 32'hD9FF55AA, 4'b1111, 32'h0, 4'b0);
    set_beats(8, 2, 32'h04030201, 4'b1111, 32'h00D9FF05, 4'b0111);
`else
    set_beats(0, 1, 32'h000000FF, 4'b0011, 32'h0, 4'b0);
    set_beats(1, 1, 32'h3412CDAB, 4'b1111, 32'h0, 4'b0);
    set_beats(2, 1, 32'h000000BF, 4'b0001, 32'h0, 4'b0);
    set_beats(3, 1, 32'h00000000, 4'b0000, 32'h0, 4'b0);
    set_beats(4, 1, 32'h003F0050, 4'b0111, 32'h0, 4'b0);
    set_beats(5, 1, 32'h001200FF, 4'b0111, 32'h0, 4'b0);
    set_beats(6, 1, 32'h000000FF, 4'b0011, 32'h0, 4'b0);
    set_beats(7, 1, 32'h000055AA, 4'b0011, 32'h0, 4'b0);
    set_beats(8, 2, 32'h04030201, 4'b1111, 32'h00000005, 4'b0001);
`endif

    // Reset state.
    rst_i = 1'b0;
    inport_valid_i = 1'b0;
    inport_data_i  = 16'h0;
    inport_width_i = 5'd0;
    inport_flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outputs", {outport_valid_o, outport_data_o, outport_strb_o, outport_last_o}, 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_in_accept", 64'(inport_accept_o), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed table.
    for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Random codes under output backpressure, checked against a bit queue.
    stall_en = 1;
    for (int i = 0; i < 64; i++) begin
      rd = 16'($urandom);
      rw = 5'($urandom_range(0, 20));
      ew = (rw > 5'd16) ? 16 : int'(rw);
      for (int b = ew - 1; b >= 0; b--) mq.push_back(rd[b]);
      send_code(rd, rw, (i == 63));
    end
    while ((mq.size() % 8) != 0) mq.push_back(1'b1);
    while (mq.size() > 0) begin
      for (int b = 7; b >= 0; b--) by[b] = mq.pop_front();
      exp_b.push_back(by);
      if (by == 8'hFF) exp_b.push_back(8'h00);
    end
`ifdef JPEG_BITPACK_EOI_EN
    exp_b.push_back(8'hFF);
    exp_b.push_back(8'hD9);
`endif
    wait_last(ok);
    stall_en = 0;
    bad_strb = 0;
    foreach (beat_q[i]) begin
      if (!beat_q[i].last && beat_q[i].strb != 4'b1111) bad_strb++;
      if (beat_q[i].last && i != beat_q.size() - 1) bad_strb++;
      for (int l = 0; l < 4; l++)
        if (beat_q[i].strb[l]) got_b.push_back(beat_q[i].data[8*l +: 8]);
    end
    check("rand_strb_last", 64'(bad_strb), 64'd0);
    check("rand_bytes", 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check($sformatf("rand_byte%0d", i), 64'(got_b[i]), 64'(exp_b[i]));
    check("rand_in_backpressure", 64'(saw_drop), 64'd1);
    beat_q.delete();
    repeat (12) @(posedge clk_i);
    #1;

    // Reset part-way through a word, then a clean segment.
    for (int i = 0; i < 5; i++) send_code(16'h0015, 5'd5, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_outputs", {outport_valid_o, outport_data_o, outport_strb_o, outport_last_o}, 64'd0);
    check("mid_rst_idle", 64'(idle_o), 64'd1);
    check("mid_rst_no_beat", 64'(beat_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    run_vec(vecs[2], "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
